// File: rtl/jtdd_vtiming_pkg.sv
// Default Double Dragon raster timing constants and the wrap-aware window test
// shared by the timing generator.
package jtdd_vtiming_pkg;

    localparam int unsigned DD_HCNT_W   = 9;
    localparam int unsigned DD_VCNT_W   = 9;
    localparam int unsigned DD_HTOTAL   = 384;
    localparam int unsigned DD_HB_START = 256;
    localparam int unsigned DD_HB_END   = 0;
    localparam int unsigned DD_HS_START = 288;
    localparam int unsigned DD_HS_END   = 320;
    localparam int unsigned DD_VTOTAL   = 272;
    localparam int unsigned DD_VB_START = 240;
    localparam int unsigned DD_VB_END   = 8;
    localparam int unsigned DD_VS_START = 248;
    localparam int unsigned DD_VS_END   = 251;
    localparam int unsigned DD_BLK_DLY  = 3;
    localparam int unsigned DD_IRQ_N    = 2;

    // Window [s,e); s>e wraps through zero, s==e is an empty window.
    function automatic logic in_range(input int unsigned x, input int unsigned s,
                                      input int unsigned e);
        if (s < e)      return (x >= s) && (x < e);
        else if (s > e) return (x >= s) || (x < e);
        else            return 1'b0;
    endfunction

endpackage

// File: rtl/jtdd_vtiming_dly.sv
// Pixel-enable gated shift register used to line up blanking with the pixel pipeline.
// DLY=0 degenerates to a wire.
module jtdd_vtiming_dly #(
    parameter int unsigned DLY = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_cen,
    input  logic i_d,
    output logic o_q
);

    if (DLY == 0) begin : g_bypass
        logic w_unused;
        assign w_unused = &{1'b0, i_clk, i_rst_n, i_cen};
        assign o_q = i_d;
    end else begin : g_shift
        logic [DLY-1:0] r_sh;

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_sh <= '0;
            end else if (i_cen) begin
                r_sh <= DLY'({r_sh, i_d});
            end
        end

        assign o_q = r_sh[DLY-1];
    end

endmodule

// File: rtl/jtdd_vtiming.sv
// Parametrised raster timing generator with programmable line interrupts.
// Define JTDD_VTIMING_FRAMECNT_EN to add the 16-bit frame counter output.
module jtdd_vtiming
    import jtdd_vtiming_pkg::*;
#(
    parameter int unsigned HCNT_W   = DD_HCNT_W,
    parameter int unsigned VCNT_W   = DD_VCNT_W,
    parameter int unsigned HTOTAL   = DD_HTOTAL,
    parameter int unsigned HB_START = DD_HB_START,
    parameter int unsigned HB_END   = DD_HB_END,
    parameter int unsigned HS_START = DD_HS_START,
    parameter int unsigned HS_END   = DD_HS_END,
    parameter int unsigned VTOTAL   = DD_VTOTAL,
    parameter int unsigned VB_START = DD_VB_START,
    parameter int unsigned VB_END   = DD_VB_END,
    parameter int unsigned VS_START = DD_VS_START,
    parameter int unsigned VS_END   = DD_VS_END,
    parameter int unsigned BLK_DLY  = DD_BLK_DLY,
    parameter int unsigned IRQ_N    = DD_IRQ_N
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pxl_cen,
    input  logic                      flip,
    input  logic [IRQ_N*VCNT_W-1:0]   irq_line,
    input  logic [IRQ_N-1:0]          irq_en,
    input  logic [IRQ_N-1:0]          irq_ack,
    output logic [HCNT_W-1:0]         hcnt,
    output logic [VCNT_W-1:0]         vcnt,
    output logic [7:0]                HPOS,
    output logic [7:0]                VPOS,
    output logic                      HBL,
    output logic                      VBL,
    output logic                      HS,
    output logic                      VS,
    output logic                      LHBL_dly,
    output logic                      LVBL_dly,
`ifdef JTDD_VTIMING_FRAMECNT_EN
    output logic [15:0]               frame_cnt,
`endif
    output logic [IRQ_N-1:0]          irq
);

    localparam logic [HCNT_W-1:0] HLAST = HCNT_W'(HTOTAL - 1);
    localparam logic [VCNT_W-1:0] VLAST = VCNT_W'(VTOTAL - 1);

    logic [HCNT_W-1:0] r_hcnt, w_hcnt_nx;
    logic [VCNT_W-1:0] r_vcnt, w_vcnt_nx;
    logic              r_hbl, r_vbl, r_hs, r_vs;
    logic [IRQ_N-1:0]  r_irq, w_irq_set;
    logic              w_hwrap, w_vwrap, w_line_cen;
    logic              w_lhbl, w_lvbl;

    assign w_hwrap    = (r_hcnt == HLAST);
    assign w_vwrap    = (r_vcnt == VLAST);
    assign w_line_cen = pxl_cen & w_hwrap;

    always_comb begin
        w_hcnt_nx = w_hwrap ? '0 : r_hcnt + 1'b1;
        w_vcnt_nx = r_vcnt;
        if (w_hwrap) w_vcnt_nx = w_vwrap ? '0 : r_vcnt + 1'b1;
    end

    // Blank/sync are decoded from the next count so they move together with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
            r_hbl  <= 1'b1;
            r_vbl  <= 1'b1;
            r_hs   <= 1'b0;
            r_vs   <= 1'b0;
        end else if (pxl_cen) begin
            r_hcnt <= w_hcnt_nx;
            r_hbl  <= in_range(32'(w_hcnt_nx), HB_START, HB_END);
            r_hs   <= in_range(32'(w_hcnt_nx), HS_START, HS_END);
            if (w_hwrap) begin
                r_vcnt <= w_vcnt_nx;
                r_vbl  <= in_range(32'(w_vcnt_nx), VB_START, VB_END);
                r_vs   <= in_range(32'(w_vcnt_nx), VS_START, VS_END);
            end
        end
    end

    // Lines beyond VTOTAL never match since the counter never reaches them.
    always_comb begin
        w_irq_set = '0;
        for (int i = 0; i < IRQ_N; i++) begin
            w_irq_set[i] = w_line_cen && irq_en[i] &&
                           (w_vcnt_nx == irq_line[i*VCNT_W +: VCNT_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_irq <= '0;
        else        r_irq <= w_irq_set | (r_irq & ~irq_ack);
    end

    assign w_lhbl = ~r_hbl;
    assign w_lvbl = ~r_vbl;

    jtdd_vtiming_dly #(.DLY(BLK_DLY)) u_lhbl_dly (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_cen   (pxl_cen),
        .i_d     (w_lhbl),
        .o_q     (LHBL_dly)
    );

    jtdd_vtiming_dly #(.DLY(BLK_DLY)) u_lvbl_dly (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_cen   (pxl_cen),
        .i_d     (w_lvbl),
        .o_q     (LVBL_dly)
    );

`ifdef JTDD_VTIMING_FRAMECNT_EN
    logic [15:0] r_frame;

    always_ff @(posedge clk) begin
        if (!rst_n)                   r_frame <= '0;
        else if (w_line_cen && w_vwrap) r_frame <= r_frame + 16'd1;
    end

    assign frame_cnt = r_frame;
`endif

    assign hcnt = r_hcnt;
    assign vcnt = r_vcnt;
    assign HPOS = r_hcnt[7:0] ^ {8{flip}};
    assign VPOS = r_vcnt[7:0] ^ {8{flip}};
    assign HBL  = r_hbl;
    assign VBL  = r_vbl;
    assign HS   = r_hs;
    assign VS   = r_vs;
    assign irq  = r_irq;

endmodule

// File: tb/tb_jtdd_vtiming.sv
// Self-checking bench for jtdd_vtiming using a compact raster geometry so whole
// frames fit in a short run; expectations come from a cen-count model.
module tb_jtdd_vtiming;

    localparam int HT = 40, HBS = 32, HBE = 4, HSS = 34, HSE = 37;
    localparam int VT = 30, VBS = 24, VBE = 2, VSS = 26, VSE = 28;
    localparam int BLK = 3, NIRQ = 2, VW = 9;

    logic clk = 1'b0;
    logic rst_n, pxl_cen, flip;
    logic [NIRQ*VW-1:0] irq_line;
    logic [NIRQ-1:0] irq_en, irq_ack, irq;
    logic [8:0] hcnt, vcnt;
    logic [7:0] HPOS, VPOS;
    logic HBL, VBL, HS, VS, LHBL_dly, LVBL_dly;
`ifdef JTDD_VTIMING_FRAMECNT_EN
    logic [15:0] frame_cnt;
`endif

    jtdd_vtiming #(
        .HCNT_W(9), .VCNT_W(VW), .HTOTAL(HT), .HB_START(HBS), .HB_END(HBE),
        .HS_START(HSS), .HS_END(HSE), .VTOTAL(VT), .VB_START(VBS), .VB_END(VBE),
        .VS_START(VSS), .VS_END(VSE), .BLK_DLY(BLK), .IRQ_N(NIRQ)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .flip(flip),
        .irq_line(irq_line), .irq_en(irq_en), .irq_ack(irq_ack),
        .hcnt(hcnt), .vcnt(vcnt), .HPOS(HPOS), .VPOS(VPOS),
        .HBL(HBL), .VBL(VBL), .HS(HS), .VS(VS),
        .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly),
`ifdef JTDD_VTIMING_FRAMECNT_EN
        .frame_cnt(frame_cnt),
`endif
        .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_n = 0;
    logic [NIRQ-1:0] m_irq = '0;

    typedef struct {
        int         n;
        logic       flip;
        logic [7:0] hpos;
        logic [7:0] vpos;
        logic       hbl;
        logic       vbl;
    } vec_t;
    vec_t tbl[6];

    function automatic bit in_rng(int x, int s, int e);
        if (s < e) return x >= s && x < e;
        if (s > e) return x >= s || x < e;
        return 1'b0;
    endfunction

    // Outputs after k cens since reset; vertical outputs first move on the first line wrap.
    function automatic bit hbl_at(int k);
        return (k == 0) ? 1'b1 : in_rng(k % HT, HBS, HBE);
    endfunction
    function automatic bit hs_at(int k);
        return (k == 0) ? 1'b0 : in_rng(k % HT, HSS, HSE);
    endfunction
    function automatic bit vbl_at(int k);
        return (k < HT) ? 1'b1 : in_rng((k / HT) % VT, VBS, VBE);
    endfunction
    function automatic bit vs_at(int k);
        return (k < HT) ? 1'b0 : in_rng((k / HT) % VT, VSS, VSE);
    endfunction

    task automatic model_tick();
        logic [NIRQ-1:0] set;
        set = '0;
        if (!rst_n) begin
            m_n   = 0;
            m_irq = '0;
        end else begin
            if (pxl_cen) begin
                m_n++;
                if (m_n % HT == 0)
                    for (int i = 0; i < NIRQ; i++)
                        set[i] = irq_en[i] && (int'(irq_line[i*VW +: VW]) == (m_n / HT) % VT);
            end
            m_irq = set | (m_irq & ~irq_ack);
        end
    endtask

    task automatic check_vec(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t n=%0d)", name, got, exp, $time, m_n);
        end
    endtask

    task automatic check_all(input string name);
        int h, v;
        logic [7:0] hp, vp;
        logic lh, lv;
        logic [41:0] got, exp;
        h  = m_n % HT;
        v  = (m_n / HT) % VT;
        hp = 8'(h) ^ {8{flip}};
        vp = 8'(v) ^ {8{flip}};
        lh = (m_n < BLK) ? 1'b0 : !hbl_at(m_n - BLK);
        lv = (m_n < BLK) ? 1'b0 : !vbl_at(m_n - BLK);
        got = {hcnt, vcnt, HPOS, VPOS, HBL, VBL, HS, VS, LHBL_dly, LVBL_dly, irq};
        exp = {9'(h), 9'(v), hp, vp, hbl_at(m_n), vbl_at(m_n), hs_at(m_n), vs_at(m_n),
               lh, lv, m_irq};
        check_vec(name, 64'(got), 64'(exp));
`ifdef JTDD_VTIMING_FRAMECNT_EN
        check_vec({name, "_frame_cnt"}, 64'(frame_cnt), 64'((m_n / (HT * VT)) & 16'hFFFF));
`endif
    endtask

    task automatic step(input logic cen);
        pxl_cen = cen;
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic run_to(input int n, input string name);
        while (m_n < n) begin
            step(1'b1);
            check_all(name);
        end
    endtask

    initial begin
        tbl[0] = '{5,    1'b0, 8'h05, 8'h00, 1'b0, 1'b1};
        tbl[1] = '{5,    1'b1, 8'hFA, 8'hFF, 1'b0, 1'b1};
        tbl[2] = '{45,   1'b1, 8'hFA, 8'hFE, 1'b0, 1'b1};
        tbl[3] = '{805,  1'b1, 8'hFA, 8'hEB, 1'b0, 1'b0};
        tbl[4] = '{805,  1'b0, 8'h05, 8'h14, 1'b0, 1'b0};
        tbl[5] = '{1199, 1'b0, 8'h27, 8'h1D, 1'b1, 1'b1};

        rst_n = 1'b0; pxl_cen = 1'b0; flip = 1'b0;
        irq_line = '0; irq_en = '0; irq_ack = '0;

        // Reset holds all outputs regardless of pxl_cen.
        for (int i = 0; i < 5; i++) begin
            step(i[0]);
            check_vec("reset_state",
                      64'({hcnt, vcnt, HBL, VBL, HS, VS, LHBL_dly, LVBL_dly, irq}),
                      64'({9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}));
        end
        rst_n = 1'b1;
        step(1'b1);
        check_vec("first_cen_hcnt", 64'(hcnt), 64'd1);
        step(1'b0);
        check_vec("hold_without_cen", 64'(hcnt), 64'd1);
        check_all("after_reset");

        for (int k = 0; k < 6; k++) begin
            run_to(tbl[k].n, "table_run");
            flip = tbl[k].flip;
            #1;
            check_vec("flip_pos", 64'({HPOS, VPOS, HBL, VBL}),
                      64'({tbl[k].hpos, tbl[k].vpos, tbl[k].hbl, tbl[k].vbl}));
        end
        flip = 1'b0;

        // Raster interrupts: set beats ack, line 0 fires on frame wrap.
        rst_n = 1'b0;
        step(1'b1);
        rst_n = 1'b1;
        irq_line = {9'd0, 9'd12};
        irq_en   = 2'b11;
        run_to(12 * HT - 1, "irq_run");
        irq_ack = 2'b01;
        step(1'b1);
        check_vec("irq0_set_beats_ack", 64'(irq), 64'b01);
        irq_ack = 2'b00;
        run_to(VT * HT - 1, "irq_run");
        step(1'b1);
        check_vec("irq1_frame_wrap", 64'(irq), 64'b11);
        irq_ack = 2'b11;
        step(1'b0);
        check_vec("irq_ack_clear", 64'(irq), 64'b00);
        irq_ack = 2'b00;

        // Unreachable target lines never fire.
        irq_line = {9'd30, 9'd300};
        run_to(2 * VT * HT, "irq_range");
        check_vec("irq_out_of_range", 64'(irq), 64'b00);
`ifdef JTDD_VTIMING_FRAMECNT_EN
        check_vec("frame_cnt_two", 64'(frame_cnt), 64'd2);
`endif

        // Disabling a channel keeps its pending flag.
        irq_line = {9'd0, 9'd3};
        irq_en   = 2'b01;
        run_to(2 * VT * HT + 3 * HT, "irq_pend");
        check_vec("irq_set_line3", 64'(irq), 64'b01);
        irq_en = 2'b00;
        run_to(2 * VT * HT + 5 * HT, "irq_pend");
        check_vec("irq_pending_en_low", 64'(irq), 64'b01);
        irq_ack = 2'b01;
        step(1'b0);
        check_vec("irq_pending_ack", 64'(irq), 64'b00);
        irq_ack = 2'b00;

        // Randomised run against the cen-count model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 199) == 0)
                irq_line = {9'($urandom_range(0, 35)), 9'($urandom_range(0, 35))};
            if ($urandom_range(0, 99) == 0) irq_en = 2'($urandom);
            irq_ack = {$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0};
            if ($urandom_range(0, 63) == 0) flip = ~flip;
            rst_n = ($urandom_range(0, 2999) != 0);
            step($urandom_range(0, 3) != 0);
            check_all("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
